bsg_chip_mem_link_arbiter: RTL and testbench



---
 rtl/bsg_chip_mem_link_arbiter.sv | 144 ++++++++++++++
 tb/tb_bsg_chip_mem_link_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_chip_mem_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bsg_chip_mem_link_arbiter: round-robin share of the off-chip memory link    |
// | between core and I/O command streams, with in-order response steering.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module bsg_chip_mem_link_arbiter #(
    parameter int msg_width_p       = 128,
    parameter int outstanding_els_p = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,

    input  logic [msg_width_p-1:0] mem_cmd_i,
    input  logic                   mem_cmd_v_i,
    output logic                   mem_cmd_yumi_o,

    input  logic [msg_width_p-1:0] io_cmd_i,
    input  logic                   io_cmd_v_i,
    output logic                   io_cmd_yumi_o,

    output logic [msg_width_p-1:0] link_cmd_o,
    output logic                   link_cmd_v_o,
    input  logic                   link_cmd_ready_i,

    input  logic [msg_width_p-1:0] link_resp_i,
    input  logic                   link_resp_v_i,
    output logic                   link_resp_yumi_o,

    output logic [msg_width_p-1:0] mem_resp_o,
    output logic                   mem_resp_v_o,
    input  logic                   mem_resp_ready_i,

    output logic [msg_width_p-1:0] io_resp_o,
    output logic                   io_resp_v_o,
    input  logic                   io_resp_ready_i,

    output logic                   error_o
);

    localparam int CNT_W = $clog2(outstanding_els_p + 1);
    localparam int PTR_W = $clog2(outstanding_els_p);
    localparam logic [CNT_W-1:0] C_MAX_COUNT = CNT_W'(outstanding_els_p);
    localparam logic [PTR_W-1:0] C_LAST_PTR  = PTR_W'(outstanding_els_p - 1);

    logic [msg_width_p-1:0]       cmd_data_q, cmd_data_d;
    logic                         cmd_v_q, cmd_v_d;
    logic                         last_q, last_d;
    logic [outstanding_els_p-1:0] tags_q, tags_d;
    logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         error_q, error_d;

    logic reg_free, grant_en, grant_mem, grant_io, grant;
    logic have_tag, head_src, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Grant path: tie goes to the source that did not win last time.
    // Gated by reset so no command is consumed while state is being cleared.
    always_comb begin
        reg_free  = ~cmd_v_q | link_cmd_ready_i;
        grant_en  = reg_free & (count_q < C_MAX_COUNT) & ~reset_i;
        grant_mem = grant_en & mem_cmd_v_i & (~io_cmd_v_i | last_q);
        grant_io  = grant_en & io_cmd_v_i & (~mem_cmd_v_i | ~last_q);
        grant     = grant_mem | grant_io;
    end

    assign mem_cmd_yumi_o = grant_mem;
    assign io_cmd_yumi_o  = grant_io;
    assign link_cmd_o     = cmd_data_q;
    assign link_cmd_v_o   = cmd_v_q;
    assign error_o        = error_q;

    // Responses come back in command order, so the FIFO head names the owner.
    always_comb begin
        have_tag         = (count_q != '0);
        head_src         = tags_q[rptr_q];
        mem_resp_v_o     = link_resp_v_i & have_tag & ~head_src;
        io_resp_v_o      = link_resp_v_i & have_tag & head_src;
        pop              = (mem_resp_v_o & mem_resp_ready_i) | (io_resp_v_o & io_resp_ready_i);
        link_resp_yumi_o = pop;
    end

    assign mem_resp_o = link_resp_i;
    assign io_resp_o  = link_resp_i;

    always_comb begin
        cmd_data_d = cmd_data_q;
        cmd_v_d    = cmd_v_q;
        last_d     = last_q;
        tags_d     = tags_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        error_d    = error_q | (link_resp_v_i & ~have_tag);

        if (grant) begin
            cmd_v_d        = 1'b1;
            cmd_data_d     = grant_io ? io_cmd_i : mem_cmd_i;
            last_d         = grant_io;
            tags_d[wptr_q] = grant_io;
            wptr_d         = ptr_inc(wptr_q);
        end else if (link_cmd_ready_i) begin
            cmd_v_d = 1'b0;
        end

        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end

        case ({grant, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_data_q <= '0;
            cmd_v_q    <= 1'b0;
            last_q     <= 1'b1;
            tags_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            cmd_data_q <= cmd_data_d;
            cmd_v_q    <= cmd_v_d;
            last_q     <= last_d;
            tags_q     <= tags_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            error_q    <= error_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_chip_mem_link_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bsg_chip_mem_link_arbiter: randomized scoreboard bench for the link     |
// | arbiter, with a transaction-level model of grants and response routing.     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_bsg_chip_mem_link_arbiter;

    localparam int W = 128;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic [W-1:0] mem_cmd_i = '0, io_cmd_i = '0, link_resp_i = '0;
    logic         mem_cmd_v_i = 0, io_cmd_v_i = 0, link_cmd_ready_i = 0, link_resp_v_i = 0;
    logic         mem_resp_ready_i = 0, io_resp_ready_i = 0;
    logic [W-1:0] link_cmd_o, mem_resp_o, io_resp_o;
    logic         mem_cmd_yumi_o, io_cmd_yumi_o, link_cmd_v_o, link_resp_yumi_o;
    logic         mem_resp_v_o, io_resp_v_o, error_o;

    bsg_chip_mem_link_arbiter #(.msg_width_p(W), .outstanding_els_p(N)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
        .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
        .link_cmd_o(link_cmd_o), .link_cmd_v_o(link_cmd_v_o), .link_cmd_ready_i(link_cmd_ready_i),
        .link_resp_i(link_resp_i), .link_resp_v_i(link_resp_v_i), .link_resp_yumi_o(link_resp_yumi_o),
        .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
        .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i),
        .error_o(error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: sources of granted-but-unanswered commands (oldest first),
    // data of granted commands not yet taken by the link, and the tie-break bit.
    bit           tag_q[$];
    logic [W-1:0] pend_q[$];
    bit           last_m = 1'b1;
    bit           err_m  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: compares the DUT against the model mid-cycle, then commits the
    // transactions that the upcoming rising edge will perform.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_i) begin
                chk("rst_mem_yumi", W'(mem_cmd_yumi_o), '0);
                chk("rst_io_yumi", W'(io_cmd_yumi_o), '0);
                chk("rst_link_v", W'(link_cmd_v_o), '0);
                chk("rst_resp_yumi", W'(link_resp_yumi_o), '0);
                chk("rst_error", W'(error_o), '0);
                tag_q.delete();
                pend_q.delete();
                last_m = 1'b1;
                err_m  = 1'b0;
            end else begin
                bit       full, may_grant, g_mem, g_io, dest, exp_pop;
                full      = (pend_q.size() != 0);
                may_grant = (!full || link_cmd_ready_i) && (tag_q.size() < N);
                g_mem = 0;
                g_io  = 0;
                if (may_grant) begin
                    if (mem_cmd_v_i && io_cmd_v_i) begin
                        g_mem = last_m;
                        g_io  = !last_m;
                    end else begin
                        g_mem = mem_cmd_v_i;
                        g_io  = io_cmd_v_i;
                    end
                end
                chk("error", W'(error_o), W'(err_m));
                chk("mem_yumi", W'(mem_cmd_yumi_o), W'(g_mem));
                chk("io_yumi", W'(io_cmd_yumi_o), W'(g_io));
                chk("link_v", W'(link_cmd_v_o), W'(full));
                if (full) chk("link_data", link_cmd_o, pend_q[0]);

                exp_pop = 0;
                if (link_resp_v_i) begin
                    if (tag_q.size() == 0) begin
                        chk("orphan_mem_v", W'(mem_resp_v_o), '0);
                        chk("orphan_io_v", W'(io_resp_v_o), '0);
                        chk("orphan_yumi", W'(link_resp_yumi_o), '0);
                        err_m = 1'b1;
                    end else begin
                        dest    = tag_q[0];
                        exp_pop = dest ? io_resp_ready_i : mem_resp_ready_i;
                        chk("mem_resp_v", W'(mem_resp_v_o), W'(!dest));
                        chk("io_resp_v", W'(io_resp_v_o), W'(dest));
                        chk("resp_yumi", W'(link_resp_yumi_o), W'(exp_pop));
                        chk("resp_data", dest ? io_resp_o : mem_resp_o, link_resp_i);
                    end
                end else begin
                    chk("idle_resp_v", W'({mem_resp_v_o, io_resp_v_o, link_resp_yumi_o}), '0);
                end

                if (exp_pop) void'(tag_q.pop_front());
                if (full && link_cmd_ready_i) void'(pend_q.pop_front());
                if (g_mem || g_io) begin
                    tag_q.push_back(g_io);
                    pend_q.push_back(g_io ? io_cmd_i : mem_cmd_i);
                    last_m = g_io;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_cmd_v_i = 0; io_cmd_v_i = 0; link_resp_v_i = 0;
        link_cmd_ready_i = 1; mem_resp_ready_i = 1; io_resp_ready_i = 1;
    endtask

    task automatic sync_reset();
        cyc();
        reset_i = 1;
        idle_inputs();
        repeat (2) cyc();
        reset_i = 0;
    endtask

    // Return link responses until nothing is outstanding, within a cycle budget.
    task automatic drain();
        int n;
        idle_inputs();
        n = 0;
        while (tag_q.size() != 0 && n < 60) begin
            link_resp_v_i = (tag_q.size() > pend_q.size());
            link_resp_i   = rnd();
            cyc();
            n++;
        end
        link_resp_v_i = 0;
        chk("drain_timeout", W'(tag_q.size()), '0);
    endtask

    initial begin
        logic [W-1:0] held;
        idle_inputs();
        mem_cmd_v_i = 1;
        repeat (3) cyc();
        reset_i = 0;
        mem_cmd_v_i = 0;

        // Both requesters valid: mem first after reset, then alternate.
        cyc();
        for (int i = 0; i < 6; i++) begin
            mem_cmd_v_i = 1; mem_cmd_i = rnd();
            io_cmd_v_i  = 1; io_cmd_i  = rnd();
            #1 chk("alt_mem", W'(mem_cmd_yumi_o), W'(i % 2 == 0));
            cyc();
        end
        drain();

        // Single command and its response.
        sync_reset();
        mem_cmd_v_i = 1; mem_cmd_i = W'(8'hA5);
        #1 chk("single_yumi", W'(mem_cmd_yumi_o), 1);
        cyc();
        mem_cmd_v_i = 0;
        #1 chk("single_link_v", W'(link_cmd_v_o), 1);
        chk("single_link_data", link_cmd_o, W'(8'hA5));
        cyc();
        link_resp_v_i = 1; link_resp_i = W'(8'h11);
        #1 chk("single_resp", W'({mem_resp_v_o, io_resp_v_o, link_resp_yumi_o}), W'(3'b101));
        chk("single_resp_data", mem_resp_o, W'(8'h11));
        cyc();
        link_resp_v_i = 0;
        drain();

        // Fill the tag FIFO; a pop does not free a slot until the next cycle.
        for (int i = 0; i < 10; i++) begin
            mem_cmd_v_i = 1; mem_cmd_i = rnd();
            #1 chk("fill_yumi", W'(mem_cmd_yumi_o), W'(i < N));
            cyc();
        end
        link_resp_v_i = 1; link_resp_i = rnd();
        #1 chk("full_pop_no_bypass", W'(mem_cmd_yumi_o), 0);
        cyc();
        link_resp_v_i = 0;
        #1 chk("full_resume", W'(mem_cmd_yumi_o), 1);
        cyc();
        drain();

        // Link backpressure holds the register and blocks grants.
        mem_cmd_v_i = 1; mem_cmd_i = rnd();
        cyc();
        held = link_cmd_o;
        io_cmd_v_i = 1; io_cmd_i = rnd(); mem_cmd_i = rnd();
        link_cmd_ready_i = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_stable", link_cmd_o, held);
            chk("bp_no_yumi", W'({mem_cmd_yumi_o, io_cmd_yumi_o}), '0);
            cyc();
        end
        link_cmd_ready_i = 1;
        #1 chk("bp_release_io", W'(io_cmd_yumi_o), 1);
        cyc();
        drain();

        // Orphan response sets the sticky error; async reset clears everything.
        link_resp_v_i = 1; link_resp_i = rnd();
        cyc();
        link_resp_v_i = 0;
        #1 chk("orphan_sticky", W'(error_o), 1);
        for (int i = 0; i < 3; i++) begin
            mem_cmd_v_i = 1; mem_cmd_i = rnd();
            cyc();
        end
        mem_cmd_v_i = 1; io_cmd_v_i = 1; link_resp_v_i = 1;
        #1 reset_i = 1;
        #1 chk("async_rst_outs", W'({mem_cmd_yumi_o, io_cmd_yumi_o, link_cmd_v_o, link_resp_yumi_o,
                                     mem_resp_v_o, io_resp_v_o, error_o}), '0);
        repeat (2) cyc();
        idle_inputs();
        reset_i = 0;
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            mem_cmd_v_i      = ($urandom_range(0, 99) < 60); mem_cmd_i = rnd();
            io_cmd_v_i       = ($urandom_range(0, 99) < 60); io_cmd_i  = rnd();
            link_cmd_ready_i = ($urandom_range(0, 99) < 70);
            link_resp_v_i    = (tag_q.size() > pend_q.size()) && ($urandom_range(0, 99) < 55);
            link_resp_i      = rnd();
            mem_resp_ready_i = ($urandom_range(0, 99) < 70);
            io_resp_ready_i  = ($urandom_range(0, 99) < 70);
            cyc();
        end
        drain();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
